ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the shared 16x8 single-clock RAM.
- Accepts one read or write per handshake from either requester.
- Drives the RAM write/read strobes and addresses, captures the RAM's registered read data, and returns a response pulse to the originating requester.
- Sits between the bus-side masters and the RAM instance; the RAM's clk/rst are tied to the same clk/rst.

---
 rtl/ram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter and sequencer for a shared single-port RAM
module ram_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  r0_valid,
   output logic                  r0_ready,
   input  logic                  r0_we,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   output logic                  r0_rsp_valid,
   output logic [DATA_WIDTH-1:0] r0_rsp_rdata,

   input  logic                  r1_valid,
   output logic                  r1_ready,
   input  logic                  r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r1_rsp_valid,
   output logic [DATA_WIDTH-1:0] r1_rsp_rdata,

   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_w_data,
   output logic                  mem_rd_enb,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_r_data,

   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RSP  = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;

   // Round-robin pointer: 0 favours requester 0 when both are valid.
   logic                  rr_ptr;

   // Command register, loaded on the accepting edge.
   logic                  cmd_we;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  cmd_id;

   // Grant decode and the selected requester's command fields.
   logic                  grant_any;
   logic                  grant_id;
   logic                  accept;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Response data path and per-requester held read data.
   logic                  rsp_fire;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic [DATA_WIDTH-1:0] r0_rdata_q;
   logic [DATA_WIDTH-1:0] r1_rdata_q;

   // Pick a requester: a lone valid wins, a tie goes to the pointer's favourite.
   always_comb begin
      grant_any = r0_valid | r1_valid;
      grant_id  = 1'b0;
      if (r0_valid && r1_valid) begin
         grant_id = rr_ptr;
      end else if (r1_valid) begin
         grant_id = 1'b1;
      end
   end

   // Readys are only offered in IDLE, and never while reset is held so no
   // requester believes a command was taken on a reset edge.
   assign accept   = (state == IDLE) && grant_any && !rst;
   assign r0_ready = accept && !grant_id;
   assign r1_ready = accept &&  grant_id;

   // Steer the granted requester's command toward the command register.
   always_comb begin
      sel_we    = r0_we;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
      if (grant_id) begin
         sel_we    = r1_we;
         sel_addr  = r1_addr;
         sel_wdata = r1_wdata;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state sequencing: one strobe cycle, one response cycle, back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = sel_we ? WR : RD;
            end
         end
         WR:      state_nxt = RSP;
         RD:      state_nxt = RSP;
         RSP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the accepted command and rotate the pointer away from the winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_id    <= 1'b0;
         rr_ptr    <= 1'b0;
      end else if (accept) begin
         cmd_we    <= sel_we;
         cmd_addr  <= sel_addr;
         cmd_wdata <= sel_wdata;
         cmd_id    <= grant_id;
         rr_ptr    <= ~grant_id;
      end
   end

   // RAM strobes: driven only in their own state, zero everywhere else.
   always_comb begin
      mem_wr_en  = 1'b0;
      mem_rd_enb = 1'b0;
      mem_addr   = '0;
      mem_w_data = '0;
      case (state)
         WR: begin
            mem_wr_en  = 1'b1;
            mem_addr   = cmd_addr;
            mem_w_data = cmd_wdata;
         end
         RD: begin
            mem_rd_enb = 1'b1;
            mem_addr   = cmd_addr;
         end
         default: begin
         end
      endcase
   end

   // The RAM has a single address; the read port just mirrors it.
   assign mem_rd_addr = mem_addr;
   assign busy        = (state != IDLE);

   // The RAM's read data is registered, so it is valid during RSP and is
   // forwarded straight through; writes complete with zero data.
   assign rsp_fire     = (state == RSP) && !rst;
   assign rsp_data     = cmd_we ? '0 : mem_r_data;
   assign r0_rsp_valid = rsp_fire && !cmd_id;
   assign r1_rsp_valid = rsp_fire &&  cmd_id;
   assign r0_rsp_rdata = r0_rsp_valid ? rsp_data : r0_rdata_q;
   assign r1_rsp_rdata = r1_rsp_valid ? rsp_data : r1_rdata_q;

   // Hold each requester's last response data between its completions.
   always_ff @(posedge clk) begin
      if (rst) begin
         r0_rdata_q <= '0;
         r1_rdata_q <= '0;
      end else begin
         if (r0_rsp_valid) begin
            r0_rdata_q <= rsp_data;
         end
         if (r1_rsp_valid) begin
            r1_rdata_q <= rsp_data;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized self-checking bench for ram_arbiter against a transaction-level model
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       r0_valid, r0_ready, r0_we, r0_rsp_valid;
   logic [3:0] r0_addr;
   logic [7:0] r0_wdata, r0_rsp_rdata;
   logic       r1_valid, r1_ready, r1_we, r1_rsp_valid;
   logic [3:0] r1_addr;
   logic [7:0] r1_wdata, r1_rsp_rdata;
   logic       mem_wr_en, mem_rd_enb, busy;
   logic [3:0] mem_addr, mem_rd_addr;
   logic [7:0] mem_w_data, mem_r_data;

   ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
      .mem_rd_enb(mem_rd_enb), .mem_rd_addr(mem_rd_addr), .mem_r_data(mem_r_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // 16x8 RAM with registered read data; writes land even while reset is held.
   logic [7:0] ram [16];
   always @(posedge clk) begin
      if (mem_wr_en) ram[mem_addr] <= mem_w_data;
      if (rst) mem_r_data <= 8'h00;
      else if (mem_rd_enb) mem_r_data <= ram[mem_rd_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transaction-level model: an accepted command is scheduled as a strobe one
   // cycle later, a response two cycles later, and the port reopens three later.
   int         cyc    = 0;
   int         free_c = 0;
   int         strb_c = -1;
   int         rsp_c  = -1;
   bit         m_ptr  = 1'b0;
   bit         t_id, t_we;
   logic [3:0] t_addr;
   logic [7:0] t_wdata, t_rdata;
   logic [7:0] ram_m [16];
   logic [7:0] last_rd [2];
   bit         hs_seen;
   bit         hs_id;
   logic [7:0] seen0, seen1;

   task automatic model_check();
      bit         s, r, idle, g_any, gid;
      logic [7:0] e_d0, e_d1;
      s = (cyc == strb_c);
      check("mem_wr_en",   mem_wr_en,   s && t_we);
      check("mem_rd_enb",  mem_rd_enb,  s && !t_we);
      check("mem_addr",    mem_addr,    s ? t_addr : 4'h0);
      check("mem_rd_addr", mem_rd_addr, s ? t_addr : 4'h0);
      check("mem_w_data",  mem_w_data,  (s && t_we) ? t_wdata : 8'h00);
      check("busy",        busy,        s || (cyc == rsp_c));

      r    = (cyc == rsp_c) && !rst;
      e_d0 = (r && !t_id) ? t_rdata : last_rd[0];
      e_d1 = (r &&  t_id) ? t_rdata : last_rd[1];
      check("r0_rsp_valid", r0_rsp_valid, r && !t_id);
      check("r1_rsp_valid", r1_rsp_valid, r &&  t_id);
      check("r0_rsp_rdata", r0_rsp_rdata, e_d0);
      check("r1_rsp_rdata", r1_rsp_rdata, e_d1);
      if (r0_rsp_valid) seen0 = r0_rsp_rdata;
      if (r1_rsp_valid) seen1 = r1_rsp_rdata;
      last_rd[0] = e_d0;
      last_rd[1] = e_d1;

      idle  = !rst && (cyc >= free_c);
      g_any = idle && (r0_valid || r1_valid);
      gid   = (r0_valid && r1_valid) ? m_ptr : r1_valid;
      check("r0_ready", r0_ready, g_any && !gid);
      check("r1_ready", r1_ready, g_any &&  gid);
      hs_seen = g_any;
      hs_id   = gid;
      if (g_any) begin
         t_id    = gid;
         t_we    = gid ? r1_we : r0_we;
         t_addr  = gid ? r1_addr : r0_addr;
         t_wdata = gid ? r1_wdata : r0_wdata;
         t_rdata = t_we ? 8'h00 : ram_m[t_addr];
         if (t_we) ram_m[t_addr] = t_wdata;
         m_ptr  = !gid;
         strb_c = cyc + 1;
         rsp_c  = cyc + 2;
         free_c = cyc + 3;
      end
      if (rst) begin
         m_ptr      = 1'b0;
         strb_c     = -1;
         rsp_c      = -1;
         free_c     = cyc + 1;
         last_rd[0] = 8'h00;
         last_rd[1] = 8'h00;
      end
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input bit id, input bit we, input logic [3:0] a, input logic [7:0] d);
      bit done = 1'b0;
      if (id) begin r1_valid = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; end
      else    begin r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; end
      for (int k = 0; k < 10 && !done; k++) begin
         tick();
         done = hs_seen && (hs_id == id);
      end
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      if (!done) check("handshake_timeout", 0, 1);
      repeat (3) tick();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         ram[i]   = 8'h00;
         ram_m[i] = 8'h00;
      end
      last_rd[0] = 8'h00;
      last_rd[1] = 8'h00;
      rst = 1'b1;
      r0_valid = 1'b0; r0_we = 1'b0; r0_addr = 4'h0; r0_wdata = 8'h00;
      r1_valid = 1'b0; r1_we = 1'b0; r1_addr = 4'h0; r1_wdata = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      tick();
      rst = 1'b0;
      repeat (10) tick();

      // Read of an unwritten location returns zero.
      req(1'b0, 1'b0, 4'h7, 8'h00);
      check("unwritten_rd7", seen0, 8'h00);

      // Write then read back through requester 0.
      req(1'b0, 1'b1, 4'h3, 8'hA5);
      req(1'b0, 1'b0, 4'h3, 8'h00);
      check("rd_after_wr3", seen0, 8'hA5);

      // Top address via requester 1, read back via requester 0.
      req(1'b1, 1'b1, 4'hF, 8'hFF);
      req(1'b0, 1'b0, 4'hF, 8'h00);
      check("rd_addr15", seen0, 8'hFF);

      // Continuous dual requests after a reset alternate starting with r0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 4'h1; r0_wdata = 8'h11;
      r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 4'h2; r1_wdata = 8'h22;
      repeat (13) tick();
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      repeat (3) tick();

      // A one-cycle valid pulse while busy is simply ignored.
      r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 4'h9; r1_wdata = 8'h3C;
      tick();
      r1_valid = 1'b0;
      r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 4'h4; r0_wdata = 8'h77;
      tick();
      r0_valid = 1'b0;
      repeat (3) tick();

      // Reset during the read strobe cycle drops the response.
      r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 4'h9;
      tick();
      r0_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (4) tick();

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 63) == 0);
         r0_valid = $urandom_range(0, 1);
         r0_we    = $urandom_range(0, 1);
         r0_addr  = 4'($urandom_range(0, 15));
         r0_wdata = 8'($urandom_range(0, 255));
         r1_valid = $urandom_range(0, 1);
         r1_we    = $urandom_range(0, 1);
         r1_addr  = 4'($urandom_range(0, 15));
         r1_wdata = 8'($urandom_range(0, 255));
         tick();
      end
      rst      = 1'b0;
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
